// File: rtl/cpu_pkg.sv
// Shared processor definitions: immediate formats and write-back sources.
package cpu_pkg;

   // Immediate format selector; codes 5-7 produce zero.
   typedef enum logic [2:0] {
      IMM_I6 = 3'd0,
      IMM_I9 = 3'd1,
      IMM_J  = 3'd2,
      IMM_UI = 3'd3,
      IMM_Z  = 3'd4
   } imm_mode_t;

   // Write-back data source.
   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MDR = 2'd1,
      WB_IMM = 2'd2,
      WB_PC  = 2'd3
   } wb_sel_t;

   // Lowest instruction bit captured by the upper-immediate register.
   localparam int UI_LSB = 7;

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator. The opcode bits instr[2:0] are not part
// of any immediate, so only instr[DATA_W-1:3] is brought in.
module imm_gen
   import cpu_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:3]      instr_f,
   input  logic [2:0]             imm_mode,
   input  logic [DATA_W-UI_LSB-1:0] ui_reg,
   output logic [DATA_W-1:0]      imm_c
);

   // Format decode; unused mode codes fall through to zero.
   always_comb begin
      // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
      imm_c = '0;
      case (imm_mode)
         IMM_I6:  imm_c = {{(DATA_W-6){instr_f[8]}}, instr_f[8:3]};
         IMM_I9:  imm_c = {{(DATA_W-9){instr_f[11]}}, instr_f[11:3]};
         // Sign-extended jump offset, pre-scaled to a half-word address.
         IMM_J:   imm_c = {{2{instr_f[DATA_W-1]}}, instr_f[DATA_W-1:3], 1'b0};
         IMM_UI:  imm_c = {ui_reg, instr_f[9:3]};
         IMM_Z:   imm_c = {{(DATA_W-6){1'b0}}, instr_f[8:3]};
         default: imm_c = '0;
      endcase
   end

endmodule

// File: rtl/regfile_operand_unit.sv
// Register file and operand stage: architectural registers with write-through
// bypass, write-back source mux, upper-immediate register and the A/B/immediate
// operand latches feeding the execute cycle.
module regfile_operand_unit
   import cpu_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int REG_COUNT = 8,
   parameter int ADDR_W    = $clog2(REG_COUNT),
   parameter int ZERO_REG  = 0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [ADDR_W-1:0] rd_a_addr,
   input  logic [ADDR_W-1:0] rd_b_addr,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [1:0]        wb_sel,
   input  logic [DATA_W-1:0] alu_out,
   input  logic [DATA_W-1:0] mdr,
   input  logic [DATA_W-1:0] pc_in,
   input  logic [DATA_W-1:0] instr,
   input  logic [2:0]        imm_mode,
   input  logic              ab_load,
   input  logic              imm_load,
   input  logic              ui_load,
   output logic [DATA_W-1:0] reg_a,
   output logic [DATA_W-1:0] reg_b,
   output logic [DATA_W-1:0] imm_out,
   output logic [DATA_W-1:0] wb_data
);

   localparam int UI_W = DATA_W - UI_LSB;

   logic [DATA_W-1:0] regs_q [REG_COUNT];
   logic [UI_W-1:0]   ui_q, ui_d;
   logic [DATA_W-1:0] reg_a_q, reg_a_d;
   logic [DATA_W-1:0] reg_b_q, reg_b_d;
   logic [DATA_W-1:0] imm_q, imm_d;
   logic [DATA_W-1:0] imm_c;
   logic              wr_eff;

   // The opcode field is decoded by the control FSM, not here.
   logic unused_opcode;
   assign unused_opcode = ^instr[2:0];

   imm_gen #(.DATA_W(DATA_W)) u_imm_gen (
      .instr_f  (instr[DATA_W-1:3]),
      .imm_mode (imm_mode),
      .ui_reg   (ui_q),
      .imm_c    (imm_c)
   );

   // Write-back source mux; the immediate source is the live imm_c, not imm_out.
   always_comb begin
      wb_data = alu_out;
      case (wb_sel)
         WB_ALU:  wb_data = alu_out;
         WB_MDR:  wb_data = mdr;
         WB_IMM:  wb_data = imm_c;
         WB_PC:   wb_data = pc_in;
         default: wb_data = alu_out;
      endcase
   end

   // A write to register 0 is discarded when it is hard-wired to zero.
   assign wr_eff = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

   // Register read with zero-register masking and same-cycle write-through.
   function automatic logic [DATA_W-1:0] read_reg(input logic [ADDR_W-1:0] addr);
      if ((ZERO_REG != 0) && (addr == '0)) begin
         return '0;
      end else if (wr_eff && (wr_addr == addr)) begin
         return wb_data;
      end
      return regs_q[addr];
   endfunction

   // Next-state selection for the operand latches and the UI register.
   always_comb begin
      reg_a_d = reg_a_q;
      reg_b_d = reg_b_q;
      imm_d   = imm_q;
      ui_d    = ui_q;
      if (ab_load) begin
         reg_a_d = read_reg(rd_a_addr);
         reg_b_d = read_reg(rd_b_addr);
      end
      if (imm_load) begin
         imm_d = imm_c;
      end
      if (ui_load) begin
         ui_d = instr[DATA_W-1:UI_LSB];
      end
   end

   // Register array: cleared on reset, written from the write-back mux.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         // NOTE: the array must read as zero straight after reset, so every entry is reset here; this keeps it in flops rather than a RAM macro.
         for (int i = 0; i < REG_COUNT; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_eff) begin
         // NOTE: non-blocking assignment so every register in this design samples pre-edge values.
         regs_q[wr_addr] <= wb_data;
      end
   end

   // Operand latches and UI register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         reg_a_q <= '0;
         reg_b_q <= '0;
         imm_q   <= '0;
         ui_q    <= '0;
      end else begin
         reg_a_q <= reg_a_d;
         reg_b_q <= reg_b_d;
         imm_q   <= imm_d;
         ui_q    <= ui_d;
      end
   end

   assign reg_a   = reg_a_q;
   assign reg_b   = reg_b_q;
   assign imm_out = imm_q;

endmodule

// File: tb/tb_regfile_operand_unit.sv
// Bench for regfile_operand_unit: two instances (ZERO_REG = 0 and 1) share one
// stimulus stream; directed table rows, a mid-cycle reset sequence and a
// randomized phase checked against a behavioural model.
module tb_regfile_operand_unit;

   logic        CLK, RST;
   logic [2:0]  rd_a_addr, rd_b_addr, wr_addr, imm_mode;
   logic        wr_en, ab_load, imm_load, ui_load;
   logic [1:0]  wb_sel;
   logic [15:0] alu_out, mdr, pc_in, instr;
   logic [15:0] reg_a0, reg_b0, imm0, wb0;
   logic [15:0] reg_a1, reg_b1, imm1, wb1;

   int total = 0;
   int bad   = 0;

   regfile_operand_unit #(.DATA_W(16), .REG_COUNT(8), .ZERO_REG(0)) u_dut0 (
      .CLK(CLK), .RST(RST), .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr),
      .wr_en(wr_en), .wr_addr(wr_addr), .wb_sel(wb_sel), .alu_out(alu_out),
      .mdr(mdr), .pc_in(pc_in), .instr(instr), .imm_mode(imm_mode),
      .ab_load(ab_load), .imm_load(imm_load), .ui_load(ui_load),
      .reg_a(reg_a0), .reg_b(reg_b0), .imm_out(imm0), .wb_data(wb0)
   );

   regfile_operand_unit #(.DATA_W(16), .REG_COUNT(8), .ZERO_REG(1)) u_dut1 (
      .CLK(CLK), .RST(RST), .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr),
      .wr_en(wr_en), .wr_addr(wr_addr), .wb_sel(wb_sel), .alu_out(alu_out),
      .mdr(mdr), .pc_in(pc_in), .instr(instr), .imm_mode(imm_mode),
      .ab_load(ab_load), .imm_load(imm_load), .ui_load(ui_load),
      .reg_a(reg_a1), .reg_b(reg_b1), .imm_out(imm1), .wb_data(wb1)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // ---------------- behavioural model (index 0: ZERO_REG=0, 1: ZERO_REG=1)
   logic [15:0] m_regs [2][8];
   logic [15:0] m_a [2];
   logic [15:0] m_b [2];
   logic [15:0] m_imm [2];
   logic [8:0]  m_ui;

   function automatic logic [15:0] model_imm(input logic [15:0] ins, input logic [2:0] mode,
                                             input logic [8:0] ui);
      int v;
      case (mode)
         3'd0: begin v = int'(ins[8:3]);  if (v >= 32)   v -= 64;   return 16'(v); end
         3'd1: begin v = int'(ins[11:3]); if (v >= 256)  v -= 512;  return 16'(v); end
         3'd2: begin v = int'(ins[15:3]); if (v >= 4096) v -= 8192; return 16'(v * 2); end
         3'd3: return 16'(int'(ui) * 128 + int'(ins[9:3]));
         3'd4: return 16'(int'(ins[8:3]));
         default: return 16'h0000;
      endcase
   endfunction

   function automatic logic [15:0] model_wb();
      case (wb_sel)
         2'd0:    return alu_out;
         2'd1:    return mdr;
         2'd2:    return model_imm(instr, imm_mode, m_ui);
         default: return pc_in;
      endcase
   endfunction

   function automatic logic [15:0] model_read(input int k, input logic [2:0] x);
      if (k == 1 && x == 3'd0) return 16'h0000;
      if (wr_en && wr_addr == x && !(k == 1 && wr_addr == 3'd0)) return model_wb();
      return m_regs[k][x];
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int r = 0; r < 8; r++) m_regs[k][r] = 16'h0000;
         m_a[k] = 16'h0000; m_b[k] = 16'h0000; m_imm[k] = 16'h0000;
      end
      m_ui = 9'h000;
   endtask

   task automatic model_step();
      logic [15:0] wb, imm;
      logic [15:0] na [2];
      logic [15:0] nb [2];
      wb  = model_wb();
      imm = model_imm(instr, imm_mode, m_ui);
      for (int k = 0; k < 2; k++) begin
         na[k] = model_read(k, rd_a_addr);
         nb[k] = model_read(k, rd_b_addr);
      end
      for (int k = 0; k < 2; k++) begin
         if (wr_en && !(k == 1 && wr_addr == 3'd0)) m_regs[k][wr_addr] = wb;
         if (ab_load) begin m_a[k] = na[k]; m_b[k] = nb[k]; end
         if (imm_load) m_imm[k] = imm;
      end
      if (ui_load) m_ui = instr[15:7];
   endtask

   // ---------------- helpers
   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle();
      wr_en = 1'b0; wr_addr = 3'd0; wb_sel = 2'd0; alu_out = 16'h0; mdr = 16'h0;
      pc_in = 16'h0; instr = 16'h0; imm_mode = 3'd0; ab_load = 1'b0;
      imm_load = 1'b0; ui_load = 1'b0; rd_a_addr = 3'd0; rd_b_addr = 3'd0;
   endtask

   // One clock: model advances on the same edge as the DUTs; returns #1 later.
   task automatic cycle();
      @(posedge CLK);
      model_step();
      #1;
   endtask

   task automatic check_all_outputs(input string tag);
      check($sformatf("%s a0", tag), reg_a0, m_a[0]);
      check($sformatf("%s a1", tag), reg_a1, m_a[1]);
      check($sformatf("%s b0", tag), reg_b0, m_b[0]);
      check($sformatf("%s b1", tag), reg_b1, m_b[1]);
      check($sformatf("%s imm0", tag), imm0, m_imm[0]);
      check($sformatf("%s imm1", tag), imm1, m_imm[1]);
   endtask

   // ---------------- directed vectors
   typedef struct {
      logic        wr_en;
      logic [2:0]  wa;
      logic [1:0]  sel;
      logic [15:0] alu, mdr, pc, instr;
      logic [2:0]  mode;
      logic        ab, il, ul;
      logic [2:0]  ra, rb;
      logic [15:0] e_a0, e_a1, e_b0, e_b1, e_imm, e_wb;
   } vec_t;

   vec_t tbl [17];

   initial begin
      // wr  wa    sel   alu       mdr       pc        instr     mode  ab    il    ul    ra    rb     a0        a1        b0        b1        imm       wb
      tbl[0]  = '{1'b1, 3'd0, 2'd1, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001};
      tbl[1]  = '{1'b1, 3'd1, 2'd1, 16'h0000, 16'h0005, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0005};
      tbl[2]  = '{1'b1, 3'd2, 2'd1, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0010};
      tbl[3]  = '{1'b0, 3'd0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd1, 16'h0001, 16'h0000, 16'h0005, 16'h0005, 16'h0000, 16'h0000};
      tbl[4]  = '{1'b1, 3'd2, 2'd0, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 3'd2, 3'd2, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h0000, 16'h1234};
      tbl[5]  = '{1'b0, 3'd0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h01F8, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'hFFFF, 16'h0000};
      tbl[6]  = '{1'b0, 3'd0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h01F8, 3'd4, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h003F, 16'h0000};
      tbl[7]  = '{1'b0, 3'd0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0068, 3'd2, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h001A, 16'h0000};
      tbl[8]  = '{1'b1, 3'd3, 2'd2, 16'h0000, 16'h0000, 16'h0000, 16'h01F8, 3'd4, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h001A, 16'h003F};
      tbl[9]  = '{1'b0, 3'd0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'hAB80, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h001A, 16'h0000};
      tbl[10] = '{1'b0, 3'd0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0018, 3'd3, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'hAB83, 16'h0000};
      tbl[11] = '{1'b1, 3'd7, 2'd3, 16'h0000, 16'h0000, 16'h0042, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'hAB83, 16'h0042};
      tbl[12] = '{1'b0, 3'd0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 3'd3, 3'd7, 16'h003F, 16'h003F, 16'h0042, 16'h0042, 16'hAB83, 16'h0000};
      tbl[13] = '{1'b0, 3'd0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0018, 3'd3, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 16'h003F, 16'h003F, 16'h0042, 16'h0042, 16'hAB83, 16'h0000};
      tbl[14] = '{1'b0, 3'd0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0018, 3'd3, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 16'h003F, 16'h003F, 16'h0042, 16'h0042, 16'h0003, 16'h0000};
      tbl[15] = '{1'b1, 3'd0, 2'd0, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 16'hBEEF, 16'h0000, 16'hBEEF, 16'h0000, 16'h0003, 16'hBEEF};
      tbl[16] = '{1'b0, 3'd0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 16'hBEEF, 16'h0000, 16'hBEEF, 16'h0000, 16'h0003, 16'h0000};

      // Power-on reset: outputs clear asynchronously.
      RST = 1'b1;
      idle();
      model_reset();
      #1;
      check("por a0", reg_a0, 16'h0);
      check("por b0", reg_b0, 16'h0);
      check("por imm0", imm0, 16'h0);
      check("por a1", reg_a1, 16'h0);
      check("por b1", reg_b1, 16'h0);
      check("por imm1", imm1, 16'h0);
      @(posedge CLK);
      #1;
      RST = 1'b0;

      // Directed table.
      for (int i = 0; i < 17; i++) begin
         wr_en = tbl[i].wr_en; wr_addr = tbl[i].wa; wb_sel = tbl[i].sel;
         alu_out = tbl[i].alu; mdr = tbl[i].mdr; pc_in = tbl[i].pc; instr = tbl[i].instr;
         imm_mode = tbl[i].mode; ab_load = tbl[i].ab; imm_load = tbl[i].il;
         ui_load = tbl[i].ul; rd_a_addr = tbl[i].ra; rd_b_addr = tbl[i].rb;
         #2;
         check($sformatf("row%0d wb0", i), wb0, tbl[i].e_wb);
         check($sformatf("row%0d wb1", i), wb1, tbl[i].e_wb);
         cycle();
         check($sformatf("row%0d a0", i), reg_a0, tbl[i].e_a0);
         check($sformatf("row%0d a1", i), reg_a1, tbl[i].e_a1);
         check($sformatf("row%0d b0", i), reg_b0, tbl[i].e_b0);
         check($sformatf("row%0d b1", i), reg_b1, tbl[i].e_b1);
         check($sformatf("row%0d imm0", i), imm0, tbl[i].e_imm);
         check($sformatf("row%0d imm1", i), imm1, tbl[i].e_imm);
      end

      // Reset asserted between edges: outputs clear without waiting for a clock.
      idle();
      #2;
      RST = 1'b1;
      #1;
      check("midrst a0", reg_a0, 16'h0);
      check("midrst b0", reg_b0, 16'h0);
      check("midrst imm0", imm0, 16'h0);
      check("midrst a1", reg_a1, 16'h0);
      check("midrst b1", reg_b1, 16'h0);
      check("midrst imm1", imm1, 16'h0);
      model_reset();
      #1;
      RST = 1'b0;

      // Every register reads zero after reset.
      for (int x = 0; x < 8; x++) begin
         rd_a_addr = 3'(x);
         rd_b_addr = 3'(7 - x);
         ab_load   = 1'b1;
         cycle();
         check($sformatf("postrst r%0d a0", x), reg_a0, 16'h0);
         check($sformatf("postrst r%0d a1", x), reg_a1, 16'h0);
         check($sformatf("postrst r%0d b0", 7 - x), reg_b0, 16'h0);
         check($sformatf("postrst r%0d b1", 7 - x), reg_b1, 16'h0);
      end

      // UI register was cleared: upper part of a UI immediate is zero.
      idle();
      instr    = 16'h0018;
      imm_mode = 3'd3;
      imm_load = 1'b1;
      cycle();
      check("postrst ui imm0", imm0, 16'h0003);
      check("postrst ui imm1", imm1, 16'h0003);

      // Randomized phase against the model.
      for (int n = 0; n < 400; n++) begin
         wr_en     = 1'($urandom_range(0, 1));
         wr_addr   = 3'($urandom_range(0, 7));
         wb_sel    = 2'($urandom_range(0, 3));
         alu_out   = 16'($urandom);
         mdr       = 16'($urandom);
         pc_in     = 16'($urandom);
         instr     = 16'($urandom);
         imm_mode  = 3'($urandom_range(0, 7));
         ab_load   = 1'($urandom_range(0, 1));
         imm_load  = 1'($urandom_range(0, 1));
         ui_load   = 1'($urandom_range(0, 3) == 0);
         rd_a_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
         rd_b_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
         #2;
         check($sformatf("rnd%0d wb0", n), wb0, model_wb());
         check($sformatf("rnd%0d wb1", n), wb1, model_wb());
         cycle();
         check_all_outputs($sformatf("rnd%0d", n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
